// File: rtl/race_arbiter.sv
// race_arbiter: round-robin owner of one race_official/race_observer pair.
// Grants one lane, runs the ready/start/done handshake, reports done or timeout.
//
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   lane_req      per-lane level request, held until done/timeout
//   lane_grant    one-hot current owner (zero when none)
//   lane_done     one-cycle completion pulse on the owner lane
//   lane_timeout  one-cycle abort pulse on the owner lane
//   off_ready     ready towards race_official
//   off_start     start from race_official
//   obs_done      done from race_observer
//   busy          high outside IDLE
//   race_count    completed races, wrapping 16-bit
module race_arbiter #(
    parameter int N_LANES = 4,
    parameter int TIMEOUT = 64,
    parameter int CW      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LANES-1:0] lane_req,
    output logic [N_LANES-1:0] lane_grant,
    output logic [N_LANES-1:0] lane_done,
    output logic [N_LANES-1:0] lane_timeout,
    output logic               off_ready,
    input  logic               off_start,
    input  logic               obs_done,
    output logic               busy,
    output logic [15:0]        race_count
);

    localparam int PW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [N_LANES-1:0] ONE = N_LANES'(1);
    localparam logic [PW:0] NL = (PW+1)'(N_LANES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        READY,
        RUN,
        COOL
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ptr_nxt;
    logic [PW-1:0]      sel;
    logic [PW:0]        idx;
    logic [PW:0]        sel_inc;
    logic               found;
    logic               held;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;
    logic [N_LANES-1:0] grant_nxt;
    logic [N_LANES-1:0] done_nxt;
    logic [N_LANES-1:0] tmo_nxt;
    logic               ready_nxt;
    logic [15:0]        count_nxt;

    // Round-robin pick: first requester at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < N_LANES; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= NL) begin
                idx = idx - NL;
            end
            if (!found && lane_req[idx[PW-1:0]]) begin
                found = 1'b1;
                sel   = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        sel_inc = {1'b0, sel} + (PW+1)'(1);
        if (sel_inc >= NL) begin
            sel_inc = '0;
        end
    end

    // Owner still asking; only matters before the official starts.
    assign held = |(lane_req & lane_grant);

    always_comb begin
        state_nxt = state;
        grant_nxt = lane_grant;
        ready_nxt = off_ready;
        done_nxt  = '0;
        tmo_nxt   = '0;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        count_nxt = race_count;
        unique case (state)
            IDLE: begin
                // Never hand out a race while the pair is still busy.
                if (found && !off_start && !obs_done) begin
                    grant_nxt = ONE << sel;
                    ready_nxt = 1'b1;
                    ptr_nxt   = sel_inc[PW-1:0];
                    state_nxt = READY;
                end
            end
            READY: begin
                if (off_start) begin
                    ready_nxt = 1'b0;
                    if (obs_done) begin
                        done_nxt  = lane_grant;
                        count_nxt = race_count + 16'd1;
                        state_nxt = COOL;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = RUN;
                    end
                end else if (!held) begin
                    ready_nxt = 1'b0;
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                // Done has priority over a simultaneous timeout.
                if (obs_done) begin
                    done_nxt  = lane_grant;
                    count_nxt = race_count + 16'd1;
                    state_nxt = COOL;
                end else if (cnt == LAST) begin
                    tmo_nxt   = lane_grant;
                    state_nxt = COOL;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            COOL: begin
                if (!off_start && !obs_done) begin
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                grant_nxt = '0;
                ready_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            lane_grant   <= '0;
            lane_done    <= '0;
            lane_timeout <= '0;
            off_ready    <= 1'b0;
            busy         <= 1'b0;
            race_count   <= '0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            cnt          <= cnt_nxt;
            lane_grant   <= grant_nxt;
            lane_done    <= done_nxt;
            lane_timeout <= tmo_nxt;
            off_ready    <= ready_nxt;
            busy         <= (state_nxt != IDLE);
            race_count   <= count_nxt;
        end
    end

endmodule

// File: tb/tb_race_arbiter.sv
// tb_race_arbiter: randomized races against a transaction-level model.
// The bench plays official/observer and predicts grants, pulses and counts.
module tb_race_arbiter;

    localparam int N   = 4;
    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] lane_req;
    logic [N-1:0] lane_grant;
    logic [N-1:0] lane_done;
    logic [N-1:0] lane_timeout;
    logic         off_ready;
    logic         off_start;
    logic         obs_done;
    logic         busy;
    logic [15:0]  race_count;

    int n_cmp = 0;
    int n_err = 0;
    int mptr  = 0;
    int mcnt  = 0;

    always #5 clk = ~clk;

    race_arbiter #(
        .N_LANES(N),
        .TIMEOUT(TMO),
        .CW(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lane_req(lane_req),
        .lane_grant(lane_grant),
        .lane_done(lane_done),
        .lane_timeout(lane_timeout),
        .off_ready(off_ready),
        .off_start(off_start),
        .obs_done(obs_done),
        .busy(busy),
        .race_count(race_count)
    );

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, o, e);
        end
    endtask

    function automatic logic [N-1:0] oh(input int e);
        logic [N-1:0] r;
        r = '0;
        if (e >= 0) r = N'(1) << e;
        return r;
    endfunction

    // Round-robin rule: first requester at or after p, modulo N.
    function automatic int rr(input logic [N-1:0] m, input int p);
        logic [N-1:0] b;
        int k;
        for (int i = 0; i < N; i++) begin
            k = (p + i) % N;
            b = m >> k;
            if (b[0]) return k;
        end
        return -1;
    endfunction

    task automatic tick();
        logic ok;
        @(posedge clk);
        #1;
        ok = $onehot0(lane_grant) && $onehot0(lane_done) &&
             $onehot0(lane_timeout) &&
             !((|lane_done) && (|lane_timeout)) &&
             ((lane_done & ~lane_grant) == '0) &&
             ((lane_timeout & ~lane_grant) == '0) &&
             (!off_ready || busy);
        chk("invariant", 32'(ok), 32'(1));
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        lane_req  = '0;
        off_start = 1'b0;
        obs_done  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        mptr = 0;
        mcnt = 0;
    endtask

    // kind: 0 normal done, 1 start+done together, 2 timeout,
    //       3 withdraw before start, 4 reset in RUN
    task automatic run_race(input logic [N-1:0] mask, input int kind,
                            input int d1, input int d2, input int gap,
                            input bit blk);
        int e;
        int d;
        bit sb;
        logic hold;
        logic [N-1:0] g;
        for (int i = 0; i < gap; i++) begin
            sb        = 1'($urandom_range(0, 1));
            lane_req  = blk ? mask : '0;
            off_start = blk & sb;
            obs_done  = blk & ~sb;
            tick();
            chk("gap_grant", 32'(lane_grant), 32'(0));
            chk("gap_busy", 32'(busy), 32'(0));
        end
        off_start = 1'b0;
        obs_done  = 1'b0;
        lane_req  = mask;
        tick();
        e = rr(mask, mptr);
        g = oh(e);
        chk("grant", 32'(lane_grant), 32'(g));
        chk("ready", 32'(off_ready), 32'(1));
        chk("busy", 32'(busy), 32'(1));
        mptr = (e + 1) % N;
        for (int i = 1; i < d1; i++) begin
            tick();
            chk("ready_hold", 32'(off_ready), 32'(1));
            chk("grant_hold", 32'(lane_grant), 32'(g));
        end
        if (kind == 3) begin
            lane_req = mask & ~g;
            tick();
            chk("wd_grant", 32'(lane_grant), 32'(0));
            chk("wd_ready", 32'(off_ready), 32'(0));
            chk("wd_pulse", 32'(lane_done | lane_timeout), 32'(0));
            chk("wd_busy", 32'(busy), 32'(0));
            return;
        end
        off_start = 1'b1;
        obs_done  = (kind == 1);
        tick();
        chk("start_ready", 32'(off_ready), 32'(0));
        if (kind == 1) begin
            mcnt++;
            chk("same_done", 32'(lane_done), 32'(g));
        end else begin
            off_start = 1'b0;
            chk("run_busy", 32'(busy), 32'(1));
            if (kind == 4) begin
                tick();
                tick();
                #2 rst = 1'b1;
                #1;
                chk("rst_grant", 32'(lane_grant), 32'(0));
                chk("rst_ready", 32'(off_ready), 32'(0));
                chk("rst_pulse", 32'(lane_done | lane_timeout), 32'(0));
                chk("rst_busy", 32'(busy), 32'(0));
                chk("rst_count", 32'(race_count), 32'(0));
                mptr     = 0;
                mcnt     = 0;
                lane_req = '0;
                @(posedge clk);
                #1;
                chk("rst_hold", 32'(lane_grant), 32'(0));
                rst = 1'b0;
                return;
            end
            if (kind == 2) lane_req = mask & ~g;
            d = (kind == 2) ? TMO : d2;
            for (int i = 1; i < d; i++) begin
                tick();
                chk("run_quiet", 32'(lane_done | lane_timeout), 32'(0));
            end
            obs_done = (kind == 0);
            tick();
            if (kind == 0) begin
                mcnt++;
                chk("done", 32'(lane_done), 32'(g));
                chk("done_no_tmo", 32'(lane_timeout), 32'(0));
            end else begin
                chk("tmo", 32'(lane_timeout), 32'(g));
                chk("tmo_no_done", 32'(lane_done), 32'(0));
            end
        end
        chk("count", 32'(race_count), 32'(16'(mcnt)));
        hold = off_start | obs_done;
        tick();
        chk("pulse_clr", 32'(lane_done | lane_timeout), 32'(0));
        chk("cool_grant", 32'(lane_grant), 32'(hold ? g : N'(0)));
        if (hold) begin
            off_start = 1'b0;
            obs_done  = 1'b0;
            tick();
            chk("idle_grant", 32'(lane_grant), 32'(0));
        end
        chk("idle_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        logic [N-1:0] m;
        int k;
        int dd;
        rst       = 1'b1;
        lane_req  = '0;
        off_start = 1'b0;
        obs_done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant0", 32'(lane_grant), 32'(0));
        chk("rst_ready0", 32'(off_ready), 32'(0));
        chk("rst_done0", 32'(lane_done), 32'(0));
        chk("rst_tmo0", 32'(lane_timeout), 32'(0));
        chk("rst_busy0", 32'(busy), 32'(0));
        chk("rst_count0", 32'(race_count), 32'(0));
        rst = 1'b0;

        run_race(4'b0001, 0, 3, 5, 0, 1'b0);

        apply_reset();
        repeat (4) run_race(4'b1111, 0, 2, 3, 0, 1'b0);

        run_race(4'b0100, 2, 2, 0, 0, 1'b0);

        apply_reset();
        run_race(4'b1010, 3, 2, 0, 0, 1'b0);
        run_race(4'b1000, 0, 2, 4, 0, 1'b0);

        run_race(4'b0011, 1, 2, 0, 1, 1'b1);

        run_race(4'b0001, 0, 1, TMO, 0, 1'b0);
        run_race(4'b0010, 0, 1, TMO - 1, 0, 1'b0);

        apply_reset();
        repeat (5) run_race(4'b1111, 1, 1, 0, 0, 1'b0);
        run_race(4'b0100, 4, 2, 0, 0, 1'b0);
        run_race(4'b0010, 0, 2, 3, 0, 1'b0);

        repeat (60) begin
            m  = N'($urandom_range(1, (1 << N) - 1));
            k  = int'($urandom_range(0, 3));
            dd = ($urandom_range(0, 4) == 0) ?
                 int'($urandom_range(TMO - 4, TMO)) :
                 int'($urandom_range(1, 20));
            run_race(m, k, int'($urandom_range(1, 4)), dd,
                     int'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/race_arbiter.md
Name: race_arbiter

Overview:
- Shares one race_official / race_observer pair among N_LANES independent requesters ("lanes").
- Grants one lane at a time, round-robin.
- Drives the official's ready input and tracks the start/done handshakes, then reports completion or timeout back to the granted lane.
- Sits between the lane stimulus logic and the official/observer pair.

Parameters:
N_LANES, 4, number of requesting lanes (2..8)
TIMEOUT, 64, max cycles in RUN waiting for obs_done before abort (>=2)
CW, 8, width of the timeout counter; must satisfy 2^CW > TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
lane_req  in  N_LANES  per-lane race request, level; held until lane_done/lane_timeout
lane_grant  out  N_LANES  one-hot owner of the official; all-zero when none
lane_done  out  N_LANES  one-cycle pulse on the granted lane when its race completes
lane_timeout  out  N_LANES  one-cycle pulse on the granted lane when its race is aborted
off_ready  out  1  ready to race_official
off_start  in  1  start from race_official
obs_done  in  1  done from race_observer
busy  out  1  high in any state other than IDLE
race_count  out  16  number of completed races, wraps 16'hFFFF -> 0

Behaviour:
- Reset (async, immediate): state=IDLE; lane_grant, lane_done, lane_timeout, off_ready, busy = 0; race_count=0; rr pointer=0; timeout counter=0.
- All outputs are registered.
- States: IDLE, READY, RUN, COOL.
- IDLE:
  - If any lane_req bit is high, select the first requesting lane at or after the pointer, searching upward and wrapping modulo N_LANES.
  - On the next edge: set lane_grant to that one-hot value, off_ready=1, state=READY, pointer=granted index+1 (mod N_LANES).
  - Latency: req sampled high at edge k -> grant and off_ready high after edge k.
  - Entry into READY is blocked while off_start or obs_done is high; stay in IDLE.
- READY:
  - off_ready is held high until off_start is sampled high; then off_ready=0 and state=RUN.
  - If off_start and obs_done are sampled high together: off_ready=0, lane_done pulse, race_count+1, state=COOL.
  - Granted lane drops lane_req before off_start: off_ready=0, lane_grant=0, state=IDLE, no done/timeout pulse.
- RUN:
  - Timeout counter clears on entry and increments each cycle.
  - obs_done sampled high: lane_done[g] pulses for one cycle, race_count+1, state=COOL.
  - Counter reaches TIMEOUT-1 with obs_done still low: lane_timeout[g] pulses for one cycle, state=COOL.
  - If obs_done rises on the same edge the counter reaches TIMEOUT-1, done wins: done pulse only.
  - lane_req withdrawal is ignored once in RUN.
- COOL:
  - lane_grant is held.
  - When off_start=0 and obs_done=0 are both sampled: lane_grant=0, state=IDLE.
  - The next arbitration happens no earlier than the following edge, so there is at least one idle cycle between races.
- Invariants:
  - lane_grant is always zero or one-hot.
  - lane_done and lane_timeout are never both high; each is at most one bit high.
  - off_ready is high only in READY.
- Reset mid-race: all outputs drop asynchronously. After reset release the block re-arbitrates from pointer 0, and only once start/done are low.

Test Plan:
1. Reset, then lane_req=4'b0001; official asserts start 3 cycles after ready, observer asserts done 5 cycles later -> grant=0001 and off_ready=1 one edge after req; off_ready=0 one edge after start; lane_done=0001 for exactly 1 cycle; race_count=1; busy=0 after start/done are low.
2. lane_req=4'b1111 held, 4 races completed -> grant order 0001, 0010, 0100, 1000; race_count=4; at least one idle cycle between grants.
3. Grant lane 2, start asserted, done never asserted, TIMEOUT=64 -> lane_timeout=0100 pulses 64 cycles after RUN entry; lane_done stays 0; race_count unchanged.
4. Grant lane 1, lane_req[1] dropped before start -> off_ready falls next edge; grant=0; no pulses; lane 3 (also requesting) granted next.
5. Start and done sampled high in the same READY cycle -> direct to COOL; single lane_done pulse; race_count+1.
6. rst asserted mid-RUN with race_count=5 -> all outputs 0 immediately, race_count=0; after release with req=0010 and start/done low, grant=0010.
